// File: rtl/bus_drive_unit_if.sv
// Shared-bus bundle for bus_drive_unit: source words, drive strobes, error clear and
// registered bus/conflict outputs. master = control/datapath side, slave = the driver block.
interface bus_drive_unit_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24,
  parameter int SELW  = $clog2(NSRC),
  parameter int CNTW  = 8
);
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_out;
  logic                  err_clr;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [SELW-1:0]       bus_src;
  logic                  conflict;
  logic                  conflict_sticky;
  logic [CNTW-1:0]       conflict_count;

  modport master (
    output src_data, src_out, err_clr,
    input  bus_out, bus_valid, bus_src, conflict, conflict_sticky, conflict_count
  );

  modport slave (
    input  src_data, src_out, err_clr,
    output bus_out, bus_valid, bus_src, conflict, conflict_sticky, conflict_count
  );
endinterface

// File: rtl/bus_drive_unit.sv
// Registered fixed-priority bus driver with multi-driver conflict detection and counting.
// Optional macro BUS_KEEPER_EN: bus_out holds its last driven value in idle cycles.
module bus_drive_unit #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24,
  localparam int SELW = $clog2(NSRC),
  parameter int CNTW  = 8
) (
  input logic              clock,
  input logic              clear,
  bus_drive_unit_if.slave  bus
);

  logic             win_hit;
  logic             multi;
  logic [SELW-1:0]  win_idx;
  logic [WIDTH-1:0] win_data;

  // Ascending scan: the first strobe found is the winner, any later one marks a conflict.
  always_comb begin
    win_hit  = 1'b0;
    multi    = 1'b0;
    win_idx  = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (bus.src_out[i]) begin
        if (win_hit) begin
          multi = 1'b1;
        end else begin
          win_hit  = 1'b1;
          win_idx  = SELW'(i);
          win_data = bus.src_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      bus.bus_out         <= '0;
      bus.bus_valid       <= 1'b0;
      bus.bus_src         <= '0;
      bus.conflict        <= 1'b0;
      bus.conflict_sticky <= 1'b0;
      bus.conflict_count  <= '0;
    end else begin
      bus.conflict <= multi;

      if (win_hit) begin
        bus.bus_out   <= win_data;
        bus.bus_src   <= win_idx;
        bus.bus_valid <= 1'b1;
      end else begin
        bus.bus_valid <= 1'b0;
`ifdef BUS_KEEPER_EN
        bus.bus_out   <= bus.bus_out;
`else
        bus.bus_out   <= '0;
`endif
      end

      // err_clr wins over a same-cycle conflict; the conflict output above still reports it.
      if (bus.err_clr) begin
        bus.conflict_sticky <= 1'b0;
        bus.conflict_count  <= '0;
      end else if (multi) begin
        bus.conflict_sticky <= 1'b1;
        if (bus.conflict_count != '1)
          bus.conflict_count <= bus.conflict_count + 1'b1;
      end
    end
  end

endmodule
